cobra_io_unit: RTL

Parametrised I/O front-end between the CYBERcobra core and the board. Input path: the switch bank is optionally synchronised, debounced as a whole bank, and handed to the core as a stable value with a change pulse. Output path: core output writes are buffered in a first-word-fall-through FIFO, which a host or bench drains with a valid/ready handshake, so no core output is lost between reads.

---
 rtl/cobra_io_pkg.sv | 11 +
 rtl/cobra_io_fifo.sv | 94 +++++++++
 rtl/cobra_io_unit.sv | 123 ++++++++++++
 3 files changed

// File: rtl/cobra_io_pkg.sv
// cobra_io_pkg: default parameters shared by the CYBERcobra I/O front-end.
//   SW_W_DEF       switch bank width
//   OUT_W_DEF      core output word width
//   DEB_CYCLES_DEF consecutive identical samples to accept a switch value
//   DEPTH_DEF      output FIFO depth (power of two)
package cobra_io_pkg;
  localparam int SW_W_DEF       = 16;
  localparam int OUT_W_DEF      = 32;
  localparam int DEB_CYCLES_DEF = 4;
  localparam int DEPTH_DEF      = 4;
endpackage

// File: rtl/cobra_io_fifo.sv
// cobra_io_fifo: first-word-fall-through FIFO buffering core output words.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   wr_data_i/wr_en_i  push side (dropped and flagged in ovf_o when full
//                      unless a pop happens in the same cycle)
//   rd_data_o          head word while valid, otherwise last popped word
//   rd_valid_o         FIFO not empty
//   rd_ready_i         consumer accepts head
//   full_o, ovf_o      full flag, sticky overflow flag
//   count_o            number of words held
module cobra_io_fifo
  import cobra_io_pkg::*;
#(
  parameter int WIDTH = OUT_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             wr_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic             full_o,
  output logic             ovf_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             ovf_q, ovf_d;
  logic             empty, full, push, pop;

  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == CNT_W'(DEPTH));
    pop   = !empty && rd_ready_i;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    push  = wr_en_i && (!full || pop);

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    ovf_d    = ovf_q;

    if (push) begin
      mem_d[wr_ptr_q] = wr_data_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      last_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (wr_en_i && !push) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
      ovf_q    <= ovf_d;
    end
  end

  assign rd_data_o  = empty ? last_q : mem_q[rd_ptr_q];
  assign rd_valid_o = !empty;
  assign full_o     = full;
  assign ovf_o      = ovf_q;
  assign count_o    = count_q;

endmodule

// File: rtl/cobra_io_unit.sv
// cobra_io_unit: I/O front-end between the CYBERcobra core and the board.
// Input path: switch bank (optionally synchronised) debounced as a whole,
// presented on core_sw_o with a one-cycle sw_changed_o pulse on update.
// Output path: core output writes are queued in cobra_io_fifo and drained
// with out_valid_o/out_ready_i.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   sw_i                         raw switches
//   core_sw_o, sw_changed_o      debounced value and update pulse
//   core_out_i, core_out_we_i    core output word and push strobe
//   out_o, out_valid_o, out_ready_i  FIFO head handshake
//   full_o, ovf_o, count_o       FIFO status
// Build option: define COBRA_IO_SYNC2_EN to insert a two-flop synchroniser
// in front of the debouncer (adds two cycles of switch latency).
module cobra_io_unit
  import cobra_io_pkg::*;
#(
  parameter int SW_W       = SW_W_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [SW_W-1:0]            sw_i,
  output logic [SW_W-1:0]            core_sw_o,
  output logic                       sw_changed_o,
  input  logic [OUT_W-1:0]           core_out_i,
  input  logic                       core_out_we_i,
  output logic                       full_o,
  output logic                       ovf_o,
  output logic [OUT_W-1:0]           out_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int DEB_W = $clog2(DEB_CYCLES);
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES - 1);

  logic [SW_W-1:0]  sw_s;
  logic [SW_W-1:0]  sample_q, sample_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [SW_W-1:0]  core_sw_q, core_sw_d;
  logic             sw_changed_q, sw_changed_d;

`ifdef COBRA_IO_SYNC2_EN
  logic [SW_W-1:0] sync1_q, sync1_d;
  logic [SW_W-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = sw_i;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign sw_s = sync2_q;
`else
  assign sw_s = sw_i;
`endif

  // Any bit differing from the held sample restarts the stability count;
  // the value is committed only once the count has saturated.
  always_comb begin
    sample_d     = sample_q;
    deb_cnt_d    = deb_cnt_q;
    core_sw_d    = core_sw_q;
    sw_changed_d = 1'b0;
    if (sw_s != sample_q) begin
      sample_d  = sw_s;
      deb_cnt_d = '0;
    end else begin
      if (deb_cnt_q != DEB_MAX) deb_cnt_d = deb_cnt_q + DEB_W'(1);
      if ((deb_cnt_q == DEB_MAX) && (sample_q != core_sw_q)) begin
        core_sw_d    = sample_q;
        sw_changed_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sample_q     <= '0;
      deb_cnt_q    <= '0;
      core_sw_q    <= '0;
      sw_changed_q <= 1'b0;
    end else begin
      sample_q     <= sample_d;
      deb_cnt_q    <= deb_cnt_d;
      core_sw_q    <= core_sw_d;
      sw_changed_q <= sw_changed_d;
    end
  end

  assign core_sw_o    = core_sw_q;
  assign sw_changed_o = sw_changed_q;

  cobra_io_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_data_i  (core_out_i),
    .wr_en_i    (core_out_we_i),
    .rd_data_o  (out_o),
    .rd_valid_o (out_valid_o),
    .rd_ready_i (out_ready_i),
    .full_o     (full_o),
    .ovf_o      (ovf_o),
    .count_o    (count_o)
  );

endmodule
